// File: rtl/mem_rd_pkg.sv
// Shared types and defaults for the memory read-port arbiter.
package mem_rd_pkg;

  // Handshake sequencer states; encodings are fixed.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRead = 2'b01,
    StWait = 2'b10,
    StDone = 2'b11
  } state_e;

  // Completion status carried from WAIT into DONE.
  typedef enum logic {
    StatOk      = 1'b0,
    StatTimeout = 1'b1
  } status_e;

  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefMaxWait = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request scanning upward from the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  input  logic [IdxW-1:0] gnt_idx,
  output logic [NREQ-1:0] pick,
  output logic [IdxW-1:0] pick_idx
);

  logic [IdxW-1:0] ptr_q;
  int unsigned     idx;
  logic            found;

  // Rotate-priority scan starting at the pointer.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        pick[idx]   = 1'b1;
        pick_idx    = IdxW'(idx);
      end
    end
  end

  // Pointer moves one past the served requester when a transaction completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (gnt_idx == IdxW'(NREQ - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Memory read-port arbiter: round-robin grant followed by a rd/ws/ds handshake
// with a wait-state timeout.
module mem_rd_arbiter
  import mem_rd_pkg::*;
#(
  parameter int unsigned NREQ     = DefNreq,
  parameter int unsigned MAX_WAIT = DefMaxWait
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            ws,
  output logic [NREQ-1:0] gnt,
  output logic            rd,
  output logic            ds,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            busy
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  state_e          state_q;
  status_e         status_q;
  logic [CntW-1:0] cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [IdxW-1:0] gnt_idx_q;
  logic [NREQ-1:0] pick;
  logic [IdxW-1:0] pick_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .advance  (state_q == StDone),
    .gnt_idx  (gnt_idx_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Sequencer, wait counter, grant register and completion status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      status_q  <= StatOk;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_q     <= pick;
            gnt_idx_q <= pick_idx;
            state_q   <= StRead;
          end
        end
        StRead: begin
          cnt_q    <= '0;
          status_q <= StatOk;
          state_q  <= StWait;
        end
        StWait: begin
          if (!ws) begin
            status_q <= StatOk;
            state_q  <= StDone;
          end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
            // Timeout fires before the counter can reach MAX_WAIT, so it never wraps.
            status_q <= StatTimeout;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          gnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decode from registered state and status only.
  always_comb begin
    gnt  = gnt_q;
    rd   = (state_q == StRead) || (state_q == StWait);
    busy = (state_q != StIdle);
    ds   = (state_q == StDone) && (status_q == StatOk);
    err  = (state_q == StDone) && (status_q == StatTimeout);
    done = (state_q == StDone) ? gnt_q : '0;
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Randomized self-checking bench for mem_rd_arbiter with a transaction-level model.
module tb_mem_rd_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_WAIT = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            ws;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            rd, ds, err, busy;

  int checks    = 0;
  int errors    = 0;
  int model_ptr = 0;
  int cyc       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_rd_arbiter #(
    .NREQ     (NREQ),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .ws   (ws),
    .gnt  (gnt),
    .rd   (rd),
    .ds   (ds),
    .done (done),
    .err  (err),
    .busy (busy)
  );

  // Index of the requester the round-robin rule selects, -1 if none.
  function automatic int model_idx(input logic [NREQ-1:0] r, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (ptr + i) % NREQ;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int k);
    logic [NREQ-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    ws  = 1'b0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    model_ptr = 0;
  endtask

  // Runs one transaction from IDLE; ws is high for the first nws WAIT cycles.
  // Cycle 0 is the IDLE cycle in which req is presented. Ends on the IDLE cycle after DONE.
  task automatic run_txn(input logic [NREQ-1:0] r, input int nws, input bit drop,
                         output logic [NREQ-1:0] g1, output int rd_cnt, output int rd_first,
                         output int done_cyc, output int done_abs,
                         output logic [NREQ-1:0] done_v, output logic ds_v,
                         output logic err_v, output bit spurious, output bit idle_after);
    int c;
    c = 0; g1 = '0; rd_cnt = 0; rd_first = -1; done_cyc = -1; done_abs = -1;
    done_v = '0; ds_v = 1'b0; err_v = 1'b0; spurious = 1'b0; idle_after = 1'b0;
    req = r;
    ws  = 1'b0;
    while (done_cyc < 0 && c < 400) begin
      @(negedge clk);
      c++;
      if (c == 1) g1 = gnt;
      if (rd) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
      end
      if (|done) begin
        done_cyc = c;
        done_abs = cyc;
        done_v   = done;
        ds_v     = ds;
        err_v    = err;
      end else if (ds || err) begin
        spurious = 1'b1;
      end
      ws = (c >= 2) && (c < 2 + nws);
      if (drop && c == 1) req = '0;
    end
    if (done_cyc >= 0) begin
      @(negedge clk);
      idle_after = !busy && !rd && !ds && !err && (gnt == '0) && (done == '0);
    end
    req = '0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if ({gnt, done, rd, ds, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b done=%b rd=%b ds=%b err=%b busy=%b want all 0",
               gnt, done, rd, ds, err, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL idle_no_req got busy=%b gnt=%b want 0/0", busy, gnt);
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] g1, dv; logic dsv, erv; bit sp, ia;
    int rc, rf, dc, da;
    reset_dut();
    run_txn(4'b0100, 0, 1'b0, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
    checks++;
    if (g1 !== 4'b0100) begin
      errors++; $display("FAIL single_gnt got %b want 0100", g1);
    end
    checks++;
    if (rc != 2 || rf != 1) begin
      errors++; $display("FAIL single_rd got cnt=%0d first=%0d want 2/1", rc, rf);
    end
    checks++;
    if (dc != 3 || dv !== 4'b0100 || dsv !== 1'b1 || erv !== 1'b0) begin
      errors++;
      $display("FAIL single_done got cyc=%0d done=%b ds=%b err=%b want 3/0100/1/0",
               dc, dv, dsv, erv);
    end
    checks++;
    if (!ia || sp) begin
      errors++; $display("FAIL single_idle got idle=%0d spurious=%0d want 1/0", ia, sp);
    end
    model_ptr = 3;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g1, dv; logic dsv, erv; bit sp, ia;
    int rc, rf, dc, da, prev_da;
    logic [NREQ-1:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_dut();
    prev_da = -1;
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 0, 1'b0, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
      checks++;
      if (g1 !== order[i] || dv !== order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d] got gnt=%b done=%b want %b", i, g1, dv, order[i]);
      end
      if (prev_da >= 0) begin
        checks++;
        if (da - prev_da != 4) begin
          errors++; $display("FAIL rr_spacing[%0d] got %0d cycles want 4", i, da - prev_da);
        end
      end
      prev_da = da;
    end
    model_ptr = 1;
  endtask

  task automatic test_wait_states();
    logic [NREQ-1:0] g1, dv; logic dsv, erv; bit sp, ia;
    int rc, rf, dc, da;
    reset_dut();
    run_txn(4'b0010, 3, 1'b0, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
    checks++;
    if (dc != 6 || rc != 5 || rf != 1 || dsv !== 1'b1 || erv !== 1'b0 || dv !== 4'b0010) begin
      errors++;
      $display("FAIL wait3 got done_cyc=%0d rd_cnt=%0d rd_first=%0d ds=%b err=%b done=%b want 6/5/1/1/0/0010",
               dc, rc, rf, dsv, erv, dv);
    end
    model_ptr = 2;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] g1, dv; logic dsv, erv; bit sp, ia;
    int rc, rf, dc, da;
    reset_dut();
    run_txn(4'b1000, 1000, 1'b0, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
    checks++;
    if (dc != 2 + MAX_WAIT || dv !== 4'b1000 || dsv !== 1'b0 || erv !== 1'b1) begin
      errors++;
      $display("FAIL timeout got done_cyc=%0d done=%b ds=%b err=%b want %0d/1000/0/1",
               dc, dv, dsv, erv, 2 + MAX_WAIT);
    end
    checks++;
    if (sp || !ia) begin
      errors++; $display("FAIL timeout_idle got spurious=%0d idle=%0d want 0/1", sp, ia);
    end
    run_txn(4'b1001, 0, 1'b0, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
    checks++;
    if (g1 !== 4'b0001 || dc != 3 || dsv !== 1'b1 || erv !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout got gnt=%b done_cyc=%0d ds=%b err=%b want 0001/3/1/0",
               g1, dc, dsv, erv);
    end
    model_ptr = 1;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g1, dv; logic dsv, erv; bit sp, ia;
    int rc, rf, dc, da;
    reset_dut();
    req = 4'b0100;
    ws  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || rd !== 1'b1) begin
      errors++; $display("FAIL mid_wait got gnt=%b rd=%b want 0100/1", gnt, rd);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({gnt, done, rd, ds, err, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset got gnt=%b done=%b rd=%b ds=%b err=%b busy=%b want all 0",
               gnt, done, rd, ds, err, busy);
    end
    rst = 1'b0;
    req = '0;
    ws  = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    checks++;
    if (done !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_done got done=%b busy=%b want 0/0", done, busy);
    end
    run_txn(4'b0110, 0, 1'b0, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
    checks++;
    if (g1 !== 4'b0010 || dv !== 4'b0010) begin
      errors++; $display("FAIL mid_regrant got gnt=%b done=%b want 0010", g1, dv);
    end
    model_ptr = 2;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g1, dv, r, exp_g; logic dsv, erv; bit sp, ia, drop, exp_to;
    int rc, rf, dc, da, nws, k, exp_dc;
    for (int n = 0; n < 40; n++) begin
      r      = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      nws    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAX_WAIT - 2, MAX_WAIT + 3))
                                           : int'($urandom_range(0, 4));
      drop   = 1'($urandom_range(0, 1));
      k      = model_idx(r, model_ptr);
      exp_g  = onehot(k);
      exp_to = (nws >= MAX_WAIT);
      exp_dc = exp_to ? 2 + MAX_WAIT : 3 + nws;
      run_txn(r, nws, drop, g1, rc, rf, dc, da, dv, dsv, erv, sp, ia);
      checks++;
      if (g1 !== exp_g || dv !== exp_g) begin
        errors++;
        $display("FAIL rand_gnt[%0d] req=%b got gnt=%b done=%b want %b", n, r, g1, dv, exp_g);
      end
      checks++;
      if (dc != exp_dc || rc != exp_dc - 1 || rf != 1) begin
        errors++;
        $display("FAIL rand_timing[%0d] nws=%0d got done_cyc=%0d rd_cnt=%0d want %0d/%0d",
                 n, nws, dc, rc, exp_dc, exp_dc - 1);
      end
      checks++;
      if (dsv !== !exp_to || erv !== exp_to || sp || !ia) begin
        errors++;
        $display("FAIL rand_status[%0d] got ds=%b err=%b spurious=%0d idle=%0d want %b/%b/0/1",
                 n, dsv, erv, sp, ia, !exp_to, exp_to);
      end
      if (k >= 0) model_ptr = (k + 1) % NREQ;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ws  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Shares the single memory read port among `NREQ` requesters. It runs a round-robin arbitration followed by a read handshake sequence: IDLE, READ, WAIT, DONE. The memory side uses a `ws` wait-state input and `rd`/`ds` strobes. A wait-state timeout protects the port against a hung memory. The block sits between the client request logic and the memory interface, and it is the only driver of `rd`/`ds`.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `MAX_WAIT`, 15, maximum consecutive `ws`=1 cycles tolerated in WAIT before abort (1..255)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  NREQ  level request per requester; held until its `done` pulse
- `ws`  in  1  memory wait state, sampled only in WAIT
- `gnt`  out  NREQ  one-hot grant, held from READ through DONE inclusive
- `rd`  out  1  memory read enable
- `ds`  out  1  data strobe; read data valid this cycle
- `done`  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- `err`  out  1  one-cycle pulse with `done` when the transaction timed out
- `busy`  out  1  high in any state other than IDLE

## Operation
- Reset: state=IDLE, round-robin pointer=0, wait counter=0. All outputs read 0: `gnt`, `rd`, `ds`, `done`, `err`, `busy`.
- IDLE: all outputs 0. If `req`≠0, pick the first set bit scanning upward from the pointer with wrap. Register the one-hot `gnt` and go to READ. If `req`=0, stay in IDLE.
- READ: `rd`=1. Clear the wait counter. Go to WAIT unconditionally.
- WAIT: `rd`=1.
  - If `ws`=0, go to DONE with ok status.
  - If `ws`=1 and counter=MAX_WAIT-1, go to DONE with timeout status.
  - Otherwise, increment the counter and stay in WAIT.
- DONE: drive `done`=`gnt`.
  - Ok status: `ds`=1, `err`=0.
  - Timeout status: `ds`=0, `err`=1.
  - Set pointer = (granted index + 1) mod NREQ. Clear `gnt`. Go to IDLE.
- Outputs `rd`, `ds`, `busy` are decoded from the registered state only, Moore style. `err` is decoded from a registered timeout flag. There are no combinational paths from `req` or `ws` to any output.
- The next-state case covers all 4 encodings. The default goes to IDLE.
- Dropping `req` after the grant does not abort the transaction; it still completes and pulses `done`. Dropping `req` in IDLE before the grant edge means that requester is not considered.
- The pointer advances only on DONE, whether ok or timeout. Simultaneous requests are resolved purely by the pointer. No requester waits more than NREQ-1 transactions.
- Wait counter width is clog2(MAX_WAIT+1). It never wraps, because the timeout fires first.

## Timing
- Request at cycle 0 in IDLE → READ at cycle 1 (`gnt`, `rd` high) → WAIT at cycle 2 → DONE at cycle 3 (`ds`, `done`) when `ws`=0 at cycle 2.
- Minimum transaction is 4 cycles including the return to IDLE. Each `ws`=1 cycle in WAIT adds 1 cycle.
- One mandatory IDLE cycle between back-to-back transactions. Peak rate is one read per 4 cycles.
- Timeout: with `ws` held at 1, DONE (`err`=1) occurs MAX_WAIT cycles after WAIT entry.
- `rst` asserted in any state: on the next edge the state is IDLE with all outputs 0. No `done` is issued for the killed transaction and the pointer goes to 0.

## Structure
- Package `mem_rd_pkg` holds:
  - the state typedef (IDLE=2'b00, READ=2'b01, WAIT=2'b10, DONE=2'b11)
  - the status encoding (ok/timeout)
  - the default `NREQ`/`MAX_WAIT` constants
- Sub-module `rr_arbiter` (parameter NREQ) holds the pointer register and the rotate-priority pick.
  - Inputs: `clk`, `rst`, `req`, `advance`, `gnt_idx`.
  - Output: one-hot `pick`, plus the index of the picked bit.
- The parent holds the FSM, the wait counter, the grant register and output decode.

## Test plan
- Reset then `req`=4'b0100, `ws`=0 → `gnt`=0100, `rd` high cycles 1-2, `ds`=1 and `done`=0100 at cycle 3, `err`=0.
- `req`=4'b1111 held, `ws`=0 → grant order 0001, 0010, 0100, 1000, 0001, with a DONE every 4 cycles.
- Single request, `ws`=1 for 3 WAIT cycles then 0 → DONE at cycle 6 with `ds`=1, `rd` high cycles 1-5.
- `ws` stuck at 1, MAX_WAIT=15 → DONE 15 cycles after WAIT entry with `err`=1, `ds`=0, `done` pulsed. The next request is served normally.
- `rst` pulsed during WAIT of a grant to requester 2 → next cycle all outputs 0, no `done`. With `req`=4'b0110 the next grant is 0010, because the pointer was reset to 0.
